// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debounce front end.
package keypad_pkg;

    localparam int unsigned N_KEYS_DEF = 10;
    localparam int unsigned KEY_MAX_W  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Number of set bits in a key vector zero-extended to KEY_MAX_W.
    function automatic int unsigned popcount(input logic [KEY_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEY_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    function automatic logic is_onehot(input logic [KEY_MAX_W-1:0] v);
        return popcount(v) == 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/keypad_debounce_pulse.sv
// Keypad front end: synchronise, debounce and emit one one-hot pulse per accepted press.
module keypad_debounce_pulse
    import keypad_pkg::*;
#(
    parameter int unsigned N_KEYS    = N_KEYS_DEF,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] KeyIn,
    output logic [N_KEYS-1:0] Dec,
    output logic              Busy,
    output logic              MultiErr
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_KEYS-1:0] q2;
    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [N_KEYS-1:0] cand;
    logic [N_KEYS-1:0] cand_n;
    logic [N_KEYS-1:0] dec_n;
    logic              multi_err_n;
    logic              one_key;
    logic              many_keys;

    sync_2ff #(
        .WIDTH (N_KEYS)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (KeyIn),
        .q   (q2)
    );

    assign one_key   = is_onehot(KEY_MAX_W'(q2));
    assign many_keys = popcount(KEY_MAX_W'(q2)) > 1;

    // State, counter, candidate and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            Dec      <= '0;
            MultiErr <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cand     <= cand_n;
            Dec      <= dec_n;
            MultiErr <= multi_err_n;
        end
    end

    // Next-state and next-output decode; Dec and MultiErr default low every cycle.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cand_n      = cand;
        dec_n       = '0;
        multi_err_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (one_key) begin
                    cand_n  = q2;
                    cnt_n   = CNT_W'(1);
                    state_n = DEBOUNCE;
                end else if (many_keys) begin
                    multi_err_n = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (q2 != cand) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    dec_n   = cand;
                    state_n = PRESSED;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Added keys while held are ignored; only an all-clear starts release.
                if (q2 == '0) begin
                    cnt_n   = CNT_W'(1);
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (q2 != '0) begin
                    state_n = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_debounce_pulse.sv
// Self-checking bench for keypad_debounce_pulse: vector table, directed corners, random vs model.
module tb_keypad_debounce_pulse;

    localparam int NK = 10;
    localparam int DB = 4;
    localparam int NV = 18;

    logic          CLK;
    logic          RST;
    logic [NK-1:0] KeyIn;
    logic [NK-1:0] Dec;
    logic          Busy;
    logic          MultiErr;

    keypad_debounce_pulse #(
        .N_KEYS    (NK),
        .DB_CYCLES (DB)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KeyIn    (KeyIn),
        .Dec      (Dec),
        .Busy     (Busy),
        .MultiErr (MultiErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counts qualifying samples and release zeros on the synchronised stream.
    logic [NK-1:0] m_s1, m_s2, m_cand, m_dec;
    logic          m_merr, m_busy, m_held;
    int            m_qual, m_zeros;

    // Observation trackers for the directed sequences.
    int            edge_cnt = 0;
    int            pulse_cnt, first_pulse_edge, busy_fall_edge, merr_cycles;
    logic [NK-1:0] last_pulse;
    logic          busy_seen, merr_seen, prev_busy;

    typedef struct {
        logic          rst;
        logic [NK-1:0] key;
        logic [NK-1:0] dec;
        logic          busy;
        logic          merr;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NK-1:0] k);
        logic [NK-1:0] s;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_cand = '0; m_dec = '0;
            m_merr = 1'b0; m_held = 1'b0; m_qual = 0; m_zeros = 0;
        end else begin
            m_dec  = '0;
            m_merr = 1'b0;
            s      = m_s2;
            if (m_held) begin
                if (s == '0) begin
                    m_zeros++;
                    if (m_zeros == DB) begin
                        m_held  = 1'b0;
                        m_zeros = 0;
                    end
                end else begin
                    m_zeros = 0;
                end
            end else if (m_qual > 0) begin
                if (s != m_cand) begin
                    m_qual = 0;
                end else begin
                    m_qual++;
                    if (m_qual == DB) begin
                        m_dec   = m_cand;
                        m_qual  = 0;
                        m_held  = 1'b1;
                        m_zeros = 0;
                    end
                end
            end else if ($countones(s) == 1) begin
                m_cand = s;
                m_qual = 1;
            end else if ($countones(s) > 1) begin
                m_merr = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = k;
        end
        m_busy = m_held || (m_qual > 0);
    endtask

    task automatic clr_track();
        pulse_cnt = 0; first_pulse_edge = -1; busy_fall_edge = -1; merr_cycles = 0;
        last_pulse = '0; busy_seen = 1'b0; merr_seen = 1'b0;
    endtask

    // One clock: drive, model the edge, compare just after it.
    task automatic step(input logic r, input logic [NK-1:0] k);
        RST   = r;
        KeyIn = k;
        @(posedge CLK);
        model_edge(r, k);
        #1;
        check("dec_vs_model", 32'(Dec), 32'(m_dec));
        check("busy_vs_model", 32'(Busy), 32'(m_busy));
        check("merr_vs_model", 32'(MultiErr), 32'(m_merr));
        if (Dec != '0) begin
            if (pulse_cnt == 0) first_pulse_edge = edge_cnt;
            pulse_cnt++;
            last_pulse = Dec;
        end
        if (MultiErr) begin
            merr_seen = 1'b1;
            merr_cycles++;
        end
        if (Busy) busy_seen = 1'b1;
        if (prev_busy && !Busy) busy_fall_edge = edge_cnt;
        prev_busy = Busy;
        edge_cnt++;
    endtask

    task automatic do_reset();
        step(1'b1, '0);
        step(1'b1, '0);
        clr_track();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f, kind, len, a, b;
        logic [NK-1:0] kv;

        prev_busy = 1'b0;
        clr_track();
        RST = 1'b1;
        KeyIn = '0;

        // Test 1 vectors: reset, then key 3 held from e0 (rows 2..10) and released.
        for (int i = 0; i < NV; i++) begin
            vecs[i].rst  = (i < 2);
            vecs[i].key  = (i >= 2 && i <= 10) ? 10'b0000001000 : 10'b0;
            vecs[i].dec  = (i == 7) ? 10'b0000001000 : 10'b0;
            vecs[i].busy = (i >= 4 && i <= 15);
            vecs[i].merr = 1'b0;
        end
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].key);
            check($sformatf("t1_dec[%0d]", i), 32'(Dec), 32'(vecs[i].dec));
            check($sformatf("t1_busy[%0d]", i), 32'(Busy), 32'(vecs[i].busy));
            check($sformatf("t1_merr[%0d]", i), 32'(MultiErr), 32'(vecs[i].merr));
        end

        // Test 2: short burst, gap, then stable press.
        do_reset();
        step(1'b0, 10'b0000000010);
        step(1'b0, 10'b0000000010);
        step(1'b0, '0);
        f = edge_cnt;
        repeat (10) step(1'b0, 10'b0000000010);
        check("t2_pulses", 32'(pulse_cnt), 32'd1);
        check("t2_value", 32'(last_pulse), 32'h002);
        check("t2_latency", 32'(first_pulse_edge), 32'(f + DB + 1));

        // Test 3: two keys together never pulse and flag MultiErr in IDLE.
        do_reset();
        repeat (10) step(1'b0, 10'b0000010001);
        repeat (6) step(1'b0, '0);
        check("t3_pulses", 32'(pulse_cnt), 32'd0);
        check("t3_busy_seen", 32'(busy_seen), 32'd0);
        check("t3_merr_cycles", 32'(merr_cycles), 32'd10);

        // Test 4: key 5 with release bounce, then key 7.
        do_reset();
        repeat (8) step(1'b0, 10'b0000100000);
        base = edge_cnt;
        step(1'b0, '0);
        step(1'b0, 10'b0000100000);
        repeat (8) step(1'b0, '0);
        check("t4_busy_fall", 32'(busy_fall_edge), 32'(base + 7));
        check("t4_pulses_a", 32'(pulse_cnt), 32'd1);
        repeat (8) step(1'b0, 10'b0010000000);
        repeat (8) step(1'b0, '0);
        check("t4_pulses_b", 32'(pulse_cnt), 32'd2);
        check("t4_value", 32'(last_pulse), 32'h080);

        // Test 5: reset mid-debounce with key 3 still held afterwards.
        do_reset();
        repeat (4) step(1'b0, 10'b0000001000);
        check("t5_busy_mid", 32'(Busy), 32'd1);
        step(1'b1, 10'b0000001000);
        step(1'b1, 10'b0000001000);
        check("t5_busy_rst", 32'(Busy), 32'd0);
        f = edge_cnt;
        repeat (10) step(1'b0, 10'b0000001000);
        check("t5_pulses", 32'(pulse_cnt), 32'd1);
        check("t5_value", 32'(last_pulse), 32'h008);
        check("t5_latency", 32'(first_pulse_edge), 32'(f + DB + 1));

        // Test 6: extra key added while held; no MultiErr outside IDLE.
        do_reset();
        repeat (8) step(1'b0, 10'b0000000010);
        repeat (5) step(1'b0, 10'b1000000010);
        repeat (8) step(1'b0, '0);
        check("t6_pulses", 32'(pulse_cnt), 32'd1);
        check("t6_value", 32'(last_pulse), 32'h002);
        check("t6_merr_seen", 32'(merr_seen), 32'd0);
        check("t6_idle", 32'(Busy), 32'd0);

        // Random segments against the model.
        do_reset();
        for (int seg = 0; seg < 400; seg++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 14));
            kv   = '0;
            a    = int'($urandom_range(0, NK - 1));
            b    = int'($urandom_range(0, NK - 1));
            kv[a] = 1'b1;
            case (kind)
                0, 1, 2, 3, 4: repeat (len) step(1'b0, kv);
                5: repeat (len) step(1'b0, '0);
                6: begin
                    kv[b] = 1'b1;
                    repeat (len) step(1'b0, kv);
                end
                7: repeat (len) step(1'b0, ($urandom_range(0, 1) == 1) ? kv : '0);
                8: repeat (len) step(1'b0, NK'($urandom));
                default: repeat ($urandom_range(1, 2)) step(1'b1, NK'($urandom));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_debounce_pulse.md
Name: keypad_debounce_pulse

Overview:
- Front-end stage for the 10-key decimal keypad. It sits directly upstream of the decimal encoder, shift-register and 4x4 memory datapath.
- Synchronises raw, bouncy, asynchronous key lines and debounces them.
- Emits exactly one single-cycle one-hot Dec pulse per accepted press, so downstream CHK/Ce strobe once per keystroke.
- Rejects multi-key presses and bounce glitches.

Parameters:
- N_KEYS, 10, number of key lines; width of KeyIn and Dec.
- DB_CYCLES, 4, consecutive identical synchronised samples required to accept a press or a release. Must be >= 2.
- CNT_W, $clog2(DB_CYCLES)+1, width of the debounce counter (derived; do not override).

Ports:
- CLK  input  1  system clock; all flops are rising-edge.
- RST  input  1  synchronous, active-high reset.
- KeyIn  input  N_KEYS  raw key lines, active-high, asynchronous to CLK, may bounce.
- Dec  output  N_KEYS  one-hot press pulse, high for exactly one CLK cycle per accepted press.
- Busy  output  1  high while a press is being qualified, held, or released (state != IDLE).
- MultiErr  output  1  registered; high for each cycle IDLE sees more than one synchronised key set.

Behaviour:
- Interface decision: one clock, CLK; reset RST is synchronous and active-high.
- Synchroniser:
  - 2-FF chain per bit: q1 <= KeyIn, q2 <= q1.
  - The FSM consumes q2 only.
- Reset (RST high at a CLK edge):
  - q1, q2, cnt, cand cleared.
  - Dec=0, Busy=0, MultiErr=0, state=IDLE.
  - Reset mid-DEBOUNCE discards the candidate; no pulse.
  - A key still held when RST deasserts is treated as a new press and pulses after normal latency.
- States and transitions (evaluated every edge):
  - IDLE:
    - q2 == 0: stay.
    - q2 one-hot: cand <= q2, cnt <= 1, go DEBOUNCE.
    - popcount(q2) > 1: stay, MultiErr <= 1 (else 0).
  - DEBOUNCE:
    - q2 != cand: go IDLE, cnt <= 0, no pulse (bounce reject; a different key restarts from IDLE).
    - q2 == cand and cnt == DB_CYCLES-1: Dec <= cand, go PRESSED.
    - Otherwise: cnt++.
  - PRESSED:
    - q2 == 0: cnt <= 1, go RELEASE.
    - Any non-zero q2, including added keys: stay, no pulse.
  - RELEASE:
    - q2 != 0: go PRESSED (release bounce).
    - q2 == 0 and cnt == DB_CYCLES-1: go IDLE.
    - Otherwise: cnt++.
- Dec:
  - Registered; equals 0 in every cycle except the single cycle after the accepting edge.
  - Never more than one bit set.
- Latency:
  - With e0 as the edge that first samples a stable key into q1, Dec is high in the cycle following edge e0+DB_CYCLES+1 (e5 for the default).
  - Minimum spacing between two pulses: a full release qualification of DB_CYCLES edges, plus a new press.
- Busy: combinational decode, state != IDLE.
- Counter:
  - Never exceeds DB_CYCLES-1.
  - Cleared on every entry to IDLE.

Decomposition:
- Package keypad_pkg:
  - state enum {IDLE, DEBOUNCE, PRESSED, RELEASE} (2-bit).
  - N_KEYS_DEF = 10.
  - Popcount / one-hot check function.
- Sub-module sync_2ff, parameterised width: the synchroniser chain, instantiated once with width N_KEYS.

Test Plan:
1. Reset, then hold KeyIn=10'b0000001000 stable from edge e0 -> Dec=10'b0000001000 for exactly one cycle after e5; Busy rises after e2; Dec stays 0 while the key is held.
2. KeyIn=10'b0000000010 for 2 cycles, 0 for 1 cycle, then stable -> first burst produces no pulse; exactly one pulse DB_CYCLES+1 edges after the final stable sample.
3. KeyIn=10'b0000010001 (two keys) held 10 cycles -> Dec never non-zero; MultiErr high while q2 holds both bits; Busy stays 0.
4. Press key 5 (accepted), release with a bounce pattern 0,1,0,0,0,0 on bit 5 -> no second pulse; Busy falls only after 4 consecutive zero samples; then a press of key 7 yields a single pulse 10'b0010000000.
5. Assert RST at cnt==2 during DEBOUNCE with key 3 held; release RST with the key still held -> no pulse during reset; one pulse 10'b0000001000 at normal latency after RST deasserts.
6. While in PRESSED on key 1, add key 9 -> no pulse. Release both -> IDLE after 4 zero samples; MultiErr stays 0 throughout, because multi-key is checked only in IDLE.
